// File: rtl/bnn_pkg.sv
// Shared types and constants for the binary-MLP loader: FSM states, frame opcodes
// and the MLP vector geometry.
package bnn_pkg;

    localparam int NUM_NEURONS = 4;
    localparam int N_INPUTS    = 4;
    localparam int W_BITS      = 16;

    localparam logic [7:0] OPC_NOP   = 8'h00;
    localparam logic [7:0] OPC_LOAD  = 8'h01;
    localparam logic [7:0] OPC_INFER = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        GET_IN,
        EVAL,
        RESULT
    } state_e;

endpackage

// File: rtl/bnn_frame_timeout.sv
// Inter-byte idle counter for an open frame; saturates at LIMIT and flags expiry.
module bnn_frame_timeout #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i && count_q != LIMIT_C) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired_o = (count_q == LIMIT_C);

endmodule

// File: rtl/bnn_mlp_loader.sv
// Byte-stream frame decoder that loads weights/bias/input for the external binary MLP,
// sequences one inference and returns the captured result over valid/ready.
module bnn_mlp_loader
    import bnn_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic [W_BITS-1:0]   mlp_weights,
    output logic [W_BITS-1:0]   mlp_bias,
    output logic [N_INPUTS-1:0] mlp_input,
    input  logic [N_INPUTS-1:0] mlp_result,
    output logic [N_INPUTS-1:0] result,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                err,
    input  logic                err_clr
);

    state_e                state_q, state_d;
    logic [2*W_BITS-1:0]   shadow_q, shadow_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [W_BITS-1:0]     weights_q, weights_d;
    logic [W_BITS-1:0]     bias_q, bias_d;
    logic [N_INPUTS-1:0]   input_q, input_d;
    logic [N_INPUTS-1:0]   result_q, result_d;
    logic                  result_valid_q, result_valid_d;
    logic                  err_q, err_d;
    logic                  settle_q, settle_d;
    logic                  err_set;
    logic                  xfer;
    logic                  in_frame;
    logic                  expired;

    assign din_ready = (state_q == IDLE) || (state_q == LOAD_W) || (state_q == GET_IN);
    assign xfer      = din_valid && din_ready;
    assign in_frame  = (state_q == LOAD_W) || (state_q == GET_IN);

    bnn_frame_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (!in_frame || xfer),
        .en_i      (in_frame && !xfer),
        .expired_o (expired)
    );

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        shadow_d       = shadow_q;
        byte_cnt_d     = byte_cnt_q;
        weights_d      = weights_q;
        bias_d         = bias_q;
        input_d        = input_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        settle_d       = settle_q;
        err_set        = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    case (din)
                        OPC_LOAD: begin
                            state_d    = LOAD_W;
                            byte_cnt_d = '0;
                            shadow_d   = '0;
                        end
                        OPC_INFER: state_d = GET_IN;
                        OPC_NOP:   state_d = IDLE;
                        default:   err_set = 1'b1;
                    endcase
                end
            end
            LOAD_W: begin
                if (xfer) begin
                    shadow_d   = {shadow_q[2*W_BITS-9:0], din};
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    // Weights and bias switch together on the final byte only.
                    if (byte_cnt_q == 2'd3) begin
                        weights_d = shadow_d[2*W_BITS-1:W_BITS];
                        bias_d    = shadow_d[W_BITS-1:0];
                        state_d   = IDLE;
                    end
                end else if (expired) begin
                    state_d    = IDLE;
                    shadow_d   = '0;
                    byte_cnt_d = '0;
                    err_set    = 1'b1;
                end
            end
            GET_IN: begin
                if (xfer) begin
                    input_d  = din[N_INPUTS-1:0];
                    settle_d = 1'b1;
                    state_d  = EVAL;
                end else if (expired) begin
                    state_d = IDLE;
                    err_set = 1'b1;
                end
            end
            EVAL: begin
                // First EVAL cycle lets the new input ripple through the MLP before capture.
                if (settle_q) begin
                    settle_d = 1'b0;
                end else begin
                    result_d       = mlp_result;
                    result_valid_d = 1'b1;
                    state_d        = RESULT;
                end
            end
            RESULT: begin
                if (result_valid_q && result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            shadow_q       <= '0;
            byte_cnt_q     <= '0;
            weights_q      <= '0;
            bias_q         <= '0;
            input_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            settle_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            byte_cnt_q     <= byte_cnt_d;
            weights_q      <= weights_d;
            bias_q         <= bias_d;
            input_q        <= input_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
            settle_q       <= settle_d;
        end
    end

    assign mlp_weights  = weights_q;
    assign mlp_bias     = bias_q;
    assign mlp_input    = input_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err          = err_q;

endmodule

// File: tb/tb_bnn_mlp_loader.sv
// Directed bench for bnn_mlp_loader with a behavioural binary MLP wired beside it:
// neuron j fires when popcount(xnor(weight_j, input)) >= bias_j.
module tb_bnn_mlp_loader;

    localparam int T = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [15:0] mlp_weights;
    logic [15:0] mlp_bias;
    logic [3:0]  mlp_input;
    logic [3:0]  mlp_result;
    logic [3:0]  result;
    logic        result_valid;
    logic        result_ready;
    logic        err;
    logic        err_clr;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bnn_mlp_loader #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .mlp_weights  (mlp_weights),
        .mlp_bias     (mlp_bias),
        .mlp_input    (mlp_input),
        .mlp_result   (mlp_result),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .err          (err),
        .err_clr      (err_clr)
    );

    function automatic logic [3:0] mlp_eval(input logic [15:0] w, input logic [15:0] b,
                                            input logic [3:0] x);
        logic [3:0] r;
        logic [3:0] wj;
        logic [3:0] bj;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            wj = w[15-4*j -: 4];
            bj = b[15-4*j -: 4];
            r[3-j] = ($countones(~(wj ^ x)) >= int'(bj));
        end
        return r;
    endfunction

    assign mlp_result = mlp_eval(mlp_weights, mlp_bias, mlp_input);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns 1ns after the edge on which the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input logic clr = 1'b0);
        int waited;
        waited = 0;
        @(negedge clk);
        din       = b;
        din_valid = 1'b1;
        err_clr   = clr;
        while (!din_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!din_ready) check("accept_wait", din_ready, 1'b1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        step(1);
        check({tag, "_din_ready"}, din_ready, 1'b1);
        check({tag, "_rvalid"}, result_valid, 1'b0);
        check({tag, "_result"}, result, 4'h0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_weights"}, mlp_weights, 16'h0000);
        check({tag, "_bias"}, mlp_bias, 16'h0000);
        check({tag, "_input"}, mlp_input, 4'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
        send_byte(8'h01);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    // Inference with result_ready already high: valid after N+2, handed off at N+3.
    task automatic infer(input string tag, input logic [7:0] x,
                         input logic [3:0] exp_in, input logic [3:0] exp_res);
        send_byte(8'h02);
        send_byte(x);
        check({tag, "_input"}, mlp_input, exp_in);
        step(1);
        check({tag, "_valid_n1"}, result_valid, 1'b0);
        step(1);
        check({tag, "_valid_n2"}, result_valid, 1'b1);
        check({tag, "_result"}, result, exp_res);
        step(1);
        check({tag, "_valid_n3"}, result_valid, 1'b0);
        check({tag, "_ready_n3"}, din_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        din          = 8'h00;
        din_valid    = 1'b0;
        result_ready = 1'b0;
        err_clr      = 1'b0;
        step(2);
        do_reset("por");

        result_ready = 1'b1;
        infer("zero_w", 8'h00, 4'h0, 4'hF);

        // Load: weights/bias must not move until the 4th payload byte.
        send_byte(8'h01);
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'h0F);
        check("mid_frame_w", mlp_weights, 16'h0000);
        check("mid_frame_b", mlp_bias, 16'h0000);
        send_byte(8'hF0);
        check("load_w", mlp_weights, 16'hA53C);
        check("load_b", mlp_bias, 16'h0FF0);
        infer("inf_b", 8'h0B, 4'hB, 4'h9);
        check("inf_b_err", err, 1'b0);

        // Back-pressure: result and valid hold while the consumer stalls.
        result_ready = 1'b0;
        send_byte(8'h02);
        send_byte(8'h05);
        step(2);
        check("bp_valid", result_valid, 1'b1);
        check("bp_result", result, 4'h9);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("bp_hold_valid", result_valid, 1'b1);
            check("bp_hold_result", result, 4'h9);
            check("bp_hold_ready", din_ready, 1'b0);
        end
        @(negedge clk);
        result_ready = 1'b1;
        step(1);
        check("bp_done_valid", result_valid, 1'b0);
        check("bp_done_ready", din_ready, 1'b1);

        // Unknown opcode, then set/clear priority.
        send_byte(8'h7E);
        check("unk_err", err, 1'b1);
        infer("unk_inf", 8'h03, 4'h3, 4'h9);
        send_byte(8'h7E, 1'b1);
        check("set_beats_clr", err, 1'b1);
        @(negedge clk);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("clr_alone", err, 1'b0);

        // Timeout inside a load frame.
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        step(T - 2);
        check("to_early_err", err, 1'b0);
        step(6);
        check("to_err", err, 1'b1);
        check("to_ready", din_ready, 1'b1);
        check("to_keep_w", mlp_weights, 16'hA53C);
        check("to_keep_b", mlp_bias, 16'h0FF0);
        infer("to_inf", 8'h0F, 4'hF, 4'h9);

        // Reset mid-load (err is still set from the timeout).
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        do_reset("rst_load");

        // Reset while a result is pending.
        load(8'hA5, 8'h3C, 8'h0F, 8'hF0);
        result_ready = 1'b0;
        send_byte(8'h02);
        send_byte(8'h05);
        step(2);
        check("pre_rst_valid", result_valid, 1'b1);
        do_reset("rst_result");

        // Upper nibble of the input byte is ignored; weights are back to zero.
        result_ready = 1'b1;
        infer("nibble", 8'hF6, 4'h6, 4'hF);
        check("nibble_err", err, 1'b0);

        // Non-trivial bias thresholds.
        load(8'h12, 8'h34, 8'h21, 8'h32);
        check("load2_w", mlp_weights, 16'h1234);
        check("load2_b", mlp_bias, 16'h2132);
        infer("inf_d", 8'h08, 4'h8, 4'hD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
